// File: rtl/jtag_scan_sequencer.sv
// Command-driven JTAG TAP master: turns IR/DR scan or TAP-reset commands into TMS/TDI
// streams, captures TDO and keeps a cycle-exact mirror of the TAP controller state.
module jtag_scan_sequencer #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = 6
) (
    input  logic              clk,
    input  logic              TRST,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rst,
    input  logic              cmd_ir,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              TMS,
    output logic              TDI,
    input  logic              TDO,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [3:0]        tap_state
);

    typedef enum logic [3:0] {
        TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
        UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
    } tap_e;

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_RESET} seq_e;

    function automatic tap_e tap_next(input tap_e s, input logic t);
        tap_e n;
        n = TLR;
        case (s)
            TLR:     n = t ? TLR    : RTI;
            RTI:     n = t ? SEL_DR : RTI;
            SEL_DR:  n = t ? SEL_IR : CAP_DR;
            CAP_DR:  n = t ? EX1_DR : SH_DR;
            SH_DR:   n = t ? EX1_DR : SH_DR;
            EX1_DR:  n = t ? UPD_DR : PAU_DR;
            PAU_DR:  n = t ? EX2_DR : PAU_DR;
            EX2_DR:  n = t ? UPD_DR : SH_DR;
            UPD_DR:  n = t ? SEL_DR : RTI;
            SEL_IR:  n = t ? TLR    : CAP_IR;
            CAP_IR:  n = t ? EX1_IR : SH_IR;
            SH_IR:   n = t ? EX1_IR : SH_IR;
            EX1_IR:  n = t ? UPD_IR : PAU_IR;
            PAU_IR:  n = t ? EX2_IR : PAU_IR;
            EX2_IR:  n = t ? UPD_IR : SH_IR;
            UPD_IR:  n = t ? SEL_DR : RTI;
            default: n = TLR;
        endcase
        return n;
    endfunction

    seq_e              seq, seq_nxt;
    tap_e              tap, tap_nxt;
    logic              tms_q, tms_nxt;
    logic              tdi_q, tdi_nxt;
    logic              ir_q;
    logic [LEN_W-1:0]  len_q, len_clamped;
    logic [DATA_W-1:0] data_q;
    logic [LEN_W-1:0]  cnt_q, cnt_nxt;
    logic [DATA_W-1:0] cap_q, cap_nxt;
    logic [2:0]        rcnt_q, rcnt_nxt;
    logic              rsp_valid_q, rsp_valid_nxt;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_nxt;
    logic              load;
    logic              in_shift;

    assign cmd_ready   = (seq == ST_IDLE) && (tap == RTI);
    assign TMS         = tms_q;
    assign TDI         = tdi_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;
    assign tap_state   = tap;
    assign len_clamped = (cmd_len > LEN_W'(DATA_W)) ? LEN_W'(DATA_W) : cmd_len;

    // TMS/TDI for the next edge are chosen from the state the mirror is about to enter.
    always_comb begin
        tap_nxt       = tap_next(tap, tms_q);
        in_shift      = (tap == SH_DR) || (tap == SH_IR);
        cnt_nxt       = in_shift ? cnt_q + LEN_W'(1) : cnt_q;
        cap_nxt       = in_shift ? (cap_q | (DATA_W'(TDO) << cnt_q)) : cap_q;
        seq_nxt       = seq;
        tms_nxt       = 1'b0;
        tdi_nxt       = 1'b0;
        rcnt_nxt      = rcnt_q;
        rsp_valid_nxt = 1'b0;
        rsp_data_nxt  = rsp_data_q;
        load          = 1'b0;
        case (seq)
            ST_IDLE: begin
                if (cmd_valid && cmd_ready) begin
                    load     = 1'b1;
                    tms_nxt  = 1'b1;
                    rcnt_nxt = 3'd0;
                    seq_nxt  = cmd_rst ? ST_RESET : ST_SCAN;
                end
            end
            ST_SCAN: begin
                case (tap_nxt)
                    SEL_DR:         tms_nxt = ir_q;
                    SEL_IR:         tms_nxt = 1'b0;
                    CAP_DR, CAP_IR: tms_nxt = (len_q == '0);
                    SH_DR, SH_IR: begin
                        tms_nxt = (cnt_nxt == len_q - LEN_W'(1));
                        tdi_nxt = |(data_q & (DATA_W'(1) << cnt_nxt));
                    end
                    EX1_DR, EX1_IR: tms_nxt = 1'b1;
                    UPD_DR, UPD_IR: tms_nxt = 1'b0;
                    RTI: begin
                        seq_nxt       = ST_IDLE;
                        rsp_valid_nxt = 1'b1;
                        rsp_data_nxt  = cap_nxt;
                    end
                    default: begin
                        // A state no scan path visits: recover through Test-Logic-Reset.
                        seq_nxt  = ST_RESET;
                        tms_nxt  = 1'b1;
                        rcnt_nxt = 3'd0;
                    end
                endcase
            end
            ST_RESET: begin
                if (tms_q) begin
                    rcnt_nxt = rcnt_q + 3'd1;
                    tms_nxt  = (rcnt_nxt < 3'd5);
                end else begin
                    seq_nxt       = ST_IDLE;
                    rsp_valid_nxt = 1'b1;
                    rsp_data_nxt  = '0;
                end
            end
            default: seq_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge TRST) begin
        if (TRST) begin
            seq         <= ST_IDLE;
            tap         <= TLR;
            tms_q       <= 1'b0;
            tdi_q       <= 1'b0;
            ir_q        <= 1'b0;
            len_q       <= '0;
            data_q      <= '0;
            cnt_q       <= '0;
            cap_q       <= '0;
            rcnt_q      <= 3'd0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
        end else begin
            seq         <= seq_nxt;
            tap         <= tap_nxt;
            tms_q       <= tms_nxt;
            tdi_q       <= tdi_nxt;
            rcnt_q      <= rcnt_nxt;
            rsp_valid_q <= rsp_valid_nxt;
            rsp_data_q  <= rsp_data_nxt;
            if (load) begin
                ir_q   <= cmd_ir;
                len_q  <= len_clamped;
                data_q <= cmd_data;
                cnt_q  <= '0;
                cap_q  <= '0;
            end else begin
                cnt_q <= cnt_nxt;
                cap_q <= cap_nxt;
            end
        end
    end

endmodule

// File: tb/tb_jtag_scan_sequencer.sv
// Self-checking bench for jtag_scan_sequencer: table vectors, hand-written reset/abort
// sequences and randomized commands checked against an independent TAP/scan model.
module tb_jtag_scan_sequencer;

    localparam int DATA_W = 32;
    localparam int LEN_W  = 6;

    logic              clk = 1'b0;
    logic              TRST = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic              cmd_rst = 1'b0;
    logic              cmd_ir = 1'b0;
    logic [LEN_W-1:0]  cmd_len = '0;
    logic [DATA_W-1:0] cmd_data = '0;
    logic              TMS;
    logic              TDI;
    logic              TDO;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_data;
    logic [3:0]        tap_state;

    logic loop_mode = 1'b1;
    logic tdo_rand  = 1'b0;
    int   checks    = 0;
    int   errors    = 0;

    assign TDO = loop_mode ? TDI : tdo_rand;

    always #5 clk = ~clk;

    jtag_scan_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
        .clk(clk), .TRST(TRST), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_rst(cmd_rst), .cmd_ir(cmd_ir), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .TMS(TMS), .TDI(TDI), .TDO(TDO), .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .tap_state(tap_state)
    );

    // Reference TAP controller as two lookup tables indexed by the current state.
    function automatic logic [3:0] tapNext(input logic [3:0] s, input logic t);
        logic [3:0] n0 [16];
        logic [3:0] n1 [16];
        n0 = '{4'd1, 4'd1, 4'd3, 4'd4, 4'd4, 4'd6, 4'd6, 4'd4,
               4'd1, 4'd10, 4'd11, 4'd11, 4'd13, 4'd13, 4'd11, 4'd1};
        n1 = '{4'd0, 4'd2, 4'd9, 4'd5, 4'd5, 4'd8, 4'd7, 4'd8,
               4'd2, 4'd0, 4'd12, 4'd12, 4'd15, 4'd14, 4'd15, 4'd2};
        return t ? n1[s] : n0[s];
    endfunction

    logic [3:0] model_tap;
    always @(posedge clk or posedge TRST) begin
        if (TRST) model_tap <= 4'd0;
        else      model_tap <= tapNext(model_tap, TMS);
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        checkOutput("tap_state", 32'(tap_state), 32'(model_tap));
    endtask

    // Issue one command and follow it edge by edge against the spec-derived TMS/TDI streams.
    task automatic applyStimulus(input bit rst, input bit ir, input int len, input logic [31:0] data,
                                 input bit loop, input bit use_exp, input logic [31:0] exp_rsp,
                                 input int exp_edges);
        bit          tms_seq[$];
        bit          tdi_seq[$];
        logic [31:0] model_rsp;
        int          n;
        int          pre;
        int          w;
        n   = (len > DATA_W) ? DATA_W : len;
        pre = ir ? 4 : 3;
        if (rst) begin
            tms_seq = '{1, 1, 1, 1, 1, 0};
        end else begin
            tms_seq.push_back(1);
            if (ir) tms_seq.push_back(1);
            tms_seq.push_back(0);
            tms_seq.push_back(n == 0);
            for (int i = 0; i < n; i++) tms_seq.push_back(i == n - 1);
            tms_seq.push_back(1);
            tms_seq.push_back(0);
        end
        for (int k = 0; k < tms_seq.size(); k++)
            tdi_seq.push_back(!rst && k >= pre && k < pre + n && data[k - pre]);
        loop_mode = loop;
        w = 0;
        while (!cmd_ready && w < 50) begin
            tick();
            w++;
        end
        checkOutput("cmd_ready_wait", 32'(cmd_ready), 32'd1);
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_rst   = rst;
        cmd_ir    = ir;
        cmd_len   = LEN_W'(len);
        cmd_data  = data;
        tick();
        cmd_valid = 1'b0;
        cmd_rst   = 1'($urandom);
        cmd_ir    = 1'($urandom);
        cmd_len   = LEN_W'($urandom);
        cmd_data  = $urandom;
        model_rsp = '0;
        for (int k = 0; k < exp_edges; k++) begin
            checkOutput("TMS", 32'(TMS), (k < tms_seq.size()) ? 32'(tms_seq[k]) : 32'd0);
            checkOutput("TDI", 32'(TDI), (k < tdi_seq.size()) ? 32'(tdi_seq[k]) : 32'd0);
            checkOutput("cmd_ready_busy", 32'(cmd_ready), 32'd0);
            checkOutput("rsp_valid_busy", 32'(rsp_valid), 32'd0);
            tdo_rand = 1'($urandom);
            if (!rst && k >= pre && k < pre + n)
                model_rsp[k - pre] = loop ? data[k - pre] : tdo_rand;
            tick();
        end
        checkOutput("rsp_valid_done", 32'(rsp_valid), 32'd1);
        checkOutput("rsp_data", rsp_data, use_exp ? exp_rsp : model_rsp);
        checkOutput("cmd_ready_done", 32'(cmd_ready), 32'd1);
        checkOutput("tap_idle", 32'(tap_state), 32'd1);
        checkOutput("TMS_idle", 32'(TMS), 32'd0);
    endtask

    typedef struct {
        bit          rst;
        bit          ir;
        int          len;
        logic [31:0] data;
        logic [31:0] exp_rsp;
        int          exp_edges;
    } vec_t;

    vec_t vecs[9];

    initial begin
        vecs[0] = '{0, 0, 8,  32'h0000_00A5, 32'h0000_00A5, 13};
        vecs[1] = '{0, 1, 4,  32'h0000_0003, 32'h0000_0003, 10};
        vecs[2] = '{0, 0, 0,  32'hFFFF_FFFF, 32'h0000_0000, 5};
        vecs[3] = '{0, 0, 40, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 37};
        vecs[4] = '{1, 0, 7,  32'h0000_1234, 32'h0000_0000, 6};
        vecs[5] = '{0, 1, 32, 32'h8000_0001, 32'h8000_0001, 38};
        vecs[6] = '{0, 0, 1,  32'h0000_0001, 32'h0000_0001, 6};
        vecs[7] = '{0, 1, 0,  32'h0000_00FF, 32'h0000_0000, 6};
        vecs[8] = '{0, 0, 5,  32'h0000_00FF, 32'h0000_001F, 10};

        tick();
        checkOutput("rst_TMS", 32'(TMS), 32'd0);
        checkOutput("rst_TDI", 32'(TDI), 32'd0);
        checkOutput("rst_tap", 32'(tap_state), 32'd0);
        checkOutput("rst_ready", 32'(cmd_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("rst_rsp_data", rsp_data, 32'd0);
        #2 TRST = 1'b0;
        tick();
        checkOutput("post_rst_tap", 32'(tap_state), 32'd1);
        checkOutput("post_rst_ready", 32'(cmd_ready), 32'd1);
        checkOutput("post_rst_TMS", 32'(TMS), 32'd0);
        checkOutput("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);

        for (int i = 0; i < 9; i++)
            applyStimulus(vecs[i].rst, vecs[i].ir, vecs[i].len, vecs[i].data, 1'b1,
                          1'b1, vecs[i].exp_rsp, vecs[i].exp_edges);

        tick();
        tick();
        checkOutput("rsp_valid_pulse", 32'(rsp_valid), 32'd0);
        checkOutput("rsp_data_held", rsp_data, 32'h0000_001F);
        checkOutput("idle_TMS", 32'(TMS), 32'd0);
        checkOutput("idle_TDI", 32'(TDI), 32'd0);

        // Abort a DR scan in the middle of shifting with TRST.
        loop_mode = 1'b1;
        cmd_valid = 1'b1;
        cmd_rst   = 1'b0;
        cmd_ir    = 1'b0;
        cmd_len   = LEN_W'(16);
        cmd_data  = 32'h0000_BEEF;
        tick();
        cmd_valid = 1'b0;
        repeat (6) tick();
        checkOutput("abort_in_shift", 32'(tap_state), 32'd4);
        #2 TRST = 1'b1;
        #1;
        checkOutput("abort_TMS", 32'(TMS), 32'd0);
        checkOutput("abort_TDI", 32'(TDI), 32'd0);
        checkOutput("abort_tap", 32'(tap_state), 32'd0);
        checkOutput("abort_ready", 32'(cmd_ready), 32'd0);
        checkOutput("abort_rsp_valid", 32'(rsp_valid), 32'd0);
        checkOutput("abort_rsp_data", rsp_data, 32'd0);
        repeat (3) begin
            tick();
            checkOutput("abort_no_rsp", 32'(rsp_valid), 32'd0);
        end
        #2 TRST = 1'b0;
        tick();
        checkOutput("abort_repark_tap", 32'(tap_state), 32'd1);
        checkOutput("abort_repark_ready", 32'(cmd_ready), 32'd1);
        checkOutput("abort_repark_rsp", 32'(rsp_valid), 32'd0);
        applyStimulus(1'b0, 1'b0, 12, 32'h0000_0A5C, 1'b1, 1'b1, 32'h0000_0A5C, 17);

        for (int r = 0; r < 25; r++) begin
            bit          rr;
            bit          ri;
            int          rl;
            int          rn;
            logic [31:0] rd;
            rr = ($urandom_range(0, 7) == 0);
            ri = 1'($urandom);
            rl = $urandom_range(0, 40);
            rd = $urandom;
            rn = (rl > DATA_W) ? DATA_W : rl;
            applyStimulus(rr, ri, rl, rd, 1'($urandom), 1'b0, 32'd0,
                          rr ? 6 : rn + 5 + (ri ? 1 : 0));
        end

        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
